// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU use a shift-add multiplier (LSB first), DIV/DIVU a restoring
// divider (MSB first). Both work on magnitudes and fix the signs in FIN.
// Every operation takes 33 cycles: 32 CALC iterations plus one FIN cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q;        // |a| or raw a: multiplicand / dividend
  logic [31:0] b_q;        // |b| or raw b: multiplier / divisor
  logic        neg_q;      // negate product or quotient in FIN
  logic        neg_r;      // negate remainder in FIN
  logic [63:0] acc;        // mult: {product}; div: {remainder, quotient}

  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic [32:0] div_diff;
  logic        q_bit;
  logic [31:0] div_rem;
  logic [63:0] prod;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  // State register.
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values; = here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: IDLE -> CALC on start, 32 CALC cycles, then FIN.
  // NOTE: next_state gets a default first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == 5'd31) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: busy is a pure decode of the state register.
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand conditioning and per-iteration arithmetic.
  always_comb begin
    is_signed = ~op[0];
    abs_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    abs_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set; the carry becomes the new MSB after the shift.
    mul_sum   = {1'b0, acc[63:32]} + (b_q[cnt] ? {1'b0, a_q} : 33'd0);

    // Restoring step: bring in the next dividend bit (MSB first, so ~cnt)
    // and trial-subtract. The 33-bit result's sign bit is the borrow.
    rem_shift = {acc[63:32], a_q[~cnt]};
    div_diff  = rem_shift - {1'b0, b_q};
    q_bit     = ~div_diff[32];
    div_rem   = q_bit ? div_diff[31:0] : rem_shift[31:0];

    // Sign fix-up applied on the FIN edge.
    prod      = neg_q ? (~acc + 64'd1) : acc;
    if (!op_q[1]) begin
      fin_hi = prod[63:32];
      fin_lo = prod[31:0];
    end else if (b_q == 32'd0) begin
      // Divide by zero: HI returns the original dividend, LO all ones.
      fin_hi = neg_r ? (~a_q + 32'd1) : a_q;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
      fin_lo = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    end
  end

  // Datapath: launch, iterate, write back results, and MTHI/MTLO moves.
  // NOTE: all datapath flops, including HI/LO, are reset so an aborted
  // operation leaves HI/LO at zero rather than a half-computed value.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= abs_a;
            b_q   <= abs_b;
            neg_q <= is_signed & (a[31] ^ b[31]);
            neg_r <= is_signed & a[31];
            acc   <= '0;
            cnt   <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (op_q[1]) acc <= {div_rem, acc[30:0], q_bit};
          else         acc <= {mul_sum, acc[31:1]};
        end
        FIN: begin
          hi <= fin_hi;
          lo <= fin_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS core, owning the HI/LO register pair. It executes the MULT, MULTU, DIV and DIVU operations that the single-cycle ALU does not implement, and exposes `busy` so the control path can stall MFHI/MFLO and subsequent mult/div instructions. Operands come from the same register-file read ports that feed the ALU `a`/`b` inputs.

## Interface
- No parameters; datapath width is fixed at 32 bits, iteration count at 32.
- `clk` input 1 — system clock, rising-edge.
- `reset` input 1 — synchronous, active-high.
- `a` input 32 — rs operand: multiplicand or dividend.
- `b` input 32 — rt operand: multiplier or divisor.
- `op` input 2 — operation select:
  - 00 MULT
  - 01 MULTU
  - 10 DIV
  - 11 DIVU
- `start` input 1 — launches `op` on `a`/`b`. Sampled only in IDLE.
- `mthi` input 1 — write `wdata` to HI. Honoured only in IDLE.
- `mtlo` input 1 — write `wdata` to LO. Honoured only in IDLE.
- `wdata` input 32 — data for MTHI/MTLO.
- `hi` output 32 — HI register. Holds the product high word or the remainder.
- `lo` output 32 — LO register. Holds the product low word or the quotient.
- `busy` output 1 — high while an operation is in flight.
- `done` output 1 — one-cycle pulse, high in the first cycle that `hi`/`lo` show a new result.

## Operation
- States:
  - IDLE → CALC on `start`.
  - CALC stays for 32 iterations, counted by a 5-bit counter from 0 to 31, then goes to FIN.
  - FIN → IDLE, unconditionally.
- Launch (edge where IDLE and `start`=1):
  - Latch `op`.
  - Signed ops: latch |a| and |b|. Record `neg_q` = a[31]^b[31] and `neg_r` = a[31]. Both flags are 0 for unsigned ops.
  - Unsigned ops: latch a and b raw.
  - Clear the 64-bit working accumulator.
- CALC, multiply: one shift-add step per cycle, LSB-first, producing a 64-bit unsigned product.
- CALC, divide: one restoring step per cycle, MSB-first, producing a 32-bit quotient and remainder.
- FIN, multiply: negate the 64-bit product if `neg_q`. Write HI = product[63:32], LO = product[31:0].
- FIN, divide: LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r`.
- Divide by zero (b==0, any divide op): HI = a, LO = 32'hFFFFFFFF. The FSM still takes the full 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap, no flag.
- Arithmetic:
  - Magnitude of 0x80000000 is taken as unsigned 0x80000000. The working datapath is 33 bits for the divide subtract and 64 bits for the product.
  - Negation is two's complement at the destination width.
- `start`, `mthi` or `mtlo` while `busy`: ignored, with no effect on state or HI/LO.
- In IDLE:
  - `start` together with `mthi`/`mtlo` in the same cycle: `start` wins and the move is dropped.
  - `mthi` and `mtlo` together: both registers are written.
- `a`, `b` and `op` are don't-care after the launch edge.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0. An assertion of `reset` mid-operation aborts at the next edge and HI/LO return to 0.
- Launch edge E0 → `busy`=1 from E0 through E33. That is 33 cycles: 32 CALC cycles plus the FIN cycle.
- Edge E33 (FIN) updates `hi`/`lo`, sets `done`=1 and clears `busy`.
- Result latency is 33 cycles from the launch edge.
- `done` is high for exactly one cycle. A new `start` in the `done` cycle is accepted, since the unit is IDLE, so back-to-back throughput is one op per 34 cycles.
- MTHI/MTLO write at the sampling edge, so the new value is visible the next cycle.
- `busy` and `done` are registered, with no combinational path from inputs.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → after 33 cycles `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `busy` high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=0 → `hi`=100, `lo`=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Protocol: MULTU 6×7 is launched; at cycle 5 assert `start` (DIVU) and `mthi` with `wdata`=0xDEAD → both ignored, `lo`=42 at cycle 33. Relaunch and assert `reset` at cycle 10 → next cycle `hi`=`lo`=0, `busy`=0, `done` never pulses.
